// File: rtl/fft_pkg.sv
// Shared FFT package: sequencer state encoding plus the width and latency
// helpers that the AGU, BPU and sequencer all derive their sizes from.
package fft_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_LOAD   = 3'd1;
    localparam state_t ST_ISSUE  = 3'd2;
    localparam state_t ST_DRAIN  = 3'd3;
    localparam state_t ST_UNLOAD = 3'd4;

    function automatic int stage_width(input int n);
        return $clog2($clog2(n));
    endfunction

    function automatic int pair_id_width(input int n);
        return $clog2(n / 2);
    endfunction

    // Cycles from a butterfly issue until its result is ready to write back.
    function automatic int wb_latency(input int rd_latency, input int mult_latency);
        return rd_latency + mult_latency;
    endfunction

endpackage

// File: rtl/buffer.sv
// Fixed-length delay line: q is d delayed by buffer_length clocks, cleared
// by a synchronous active-high reset.
module buffer #(
    parameter int buffer_length = 3,
    parameter int vector_size   = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [vector_size-1:0] d,
    output logic [vector_size-1:0] q
);

    logic [buffer_length-1:0][vector_size-1:0] tap_reg;
    logic [buffer_length-1:0][vector_size-1:0] tap_next;

    assign tap_next[0] = d;

    genvar gi;
    generate
        for (gi = 1; gi < buffer_length; gi++) begin : g_tap
            assign tap_next[gi] = tap_reg[gi-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            tap_reg <= '0;
        end else begin
            tap_reg <= tap_next;
        end
    end

    assign q = tap_reg[buffer_length-1];

endmodule

// File: rtl/fft_sequencer.sv
// Control FSM for the in-place radix-2 FFT: load, per-stage butterfly issue
// with write-back drain, then unload. Optional FFT_SEQ_CYCLE_CNT_EN adds cycle_count.
module fft_sequencer
    import fft_pkg::*;
#(
    parameter  int N            = 32,
    parameter  int mult_latency = 2,
    parameter  int rd_latency   = 1,
    localparam int LOG2N        = $clog2(N),
    localparam int STAGE_W      = stage_width(N),
    localparam int PAIR_W       = pair_id_width(N),
    localparam int WB_LAT       = wb_latency(rd_latency, mult_latency)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               busy,
    output logic               input_en,
    input  logic               input_done,
    output logic [STAGE_W-1:0] stage,
    output logic [PAIR_W-1:0]  pair_id,
    output logic               issue_valid,
    output logic               wb_en,
    output logic               bank_select,
    output logic               output_en,
    input  logic               output_done,
`ifdef FFT_SEQ_CYCLE_CNT_EN
    output logic               done,
    output logic [31:0]        cycle_count
`else
    output logic               done
`endif
);

    localparam int DRAIN_W = $clog2(WB_LAT + 1);
    localparam logic [STAGE_W-1:0] LAST_STAGE  = STAGE_W'(LOG2N - 1);
    localparam logic [PAIR_W-1:0]  LAST_PAIR   = PAIR_W'(N / 2 - 1);
    localparam logic [DRAIN_W-1:0] LAST_DRAIN  = DRAIN_W'(WB_LAT - 1);
    localparam logic               UNLOAD_BANK = 1'(LOG2N % 2);

    state_t               state_reg, state_next;
    logic [STAGE_W-1:0]   stage_reg, stage_next;
    logic [PAIR_W-1:0]    pair_reg, pair_next;
    logic [DRAIN_W-1:0]   drain_reg, drain_next;
    logic                 bank_reg, bank_next;
    logic                 busy_reg, input_en_reg, issue_valid_reg, output_en_reg, done_reg;
    logic                 accept;

    // done_reg is high in the first IDLE cycle, so a start there is refused.
    assign accept = (state_reg == ST_IDLE) && start && !done_reg;

    always_comb begin
        state_next = state_reg;
        stage_next = stage_reg;
        pair_next  = pair_reg;
        drain_next = drain_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) state_next = ST_LOAD;
            end
            ST_LOAD: begin
                if (input_done) begin
                    state_next = ST_ISSUE;
                    stage_next = '0;
                    pair_next  = '0;
                end
            end
            ST_ISSUE: begin
                if (pair_reg == LAST_PAIR) begin
                    state_next = ST_DRAIN;
                    pair_next  = '0;
                    drain_next = '0;
                end else begin
                    pair_next = pair_reg + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (drain_reg == LAST_DRAIN) begin
                    drain_next = '0;
                    if (stage_reg == LAST_STAGE) begin
                        state_next = ST_UNLOAD;
                        stage_next = '0;
                    end else begin
                        state_next = ST_ISSUE;
                        stage_next = stage_reg + 1'b1;
                    end
                end else begin
                    drain_next = drain_reg + 1'b1;
                end
            end
            ST_UNLOAD: begin
                if (output_done) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Stage s reads bank s mod 2; the loader fills bank 0 while bank 1 is selected.
    always_comb begin
        bank_next = 1'b0;
        case (state_next)
            ST_LOAD:            bank_next = 1'b1;
            ST_ISSUE, ST_DRAIN: bank_next = stage_next[0];
            ST_UNLOAD:          bank_next = UNLOAD_BANK;
            default:            bank_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            stage_reg       <= '0;
            pair_reg        <= '0;
            drain_reg       <= '0;
            bank_reg        <= 1'b0;
            busy_reg        <= 1'b0;
            input_en_reg    <= 1'b0;
            issue_valid_reg <= 1'b0;
            output_en_reg   <= 1'b0;
            done_reg        <= 1'b0;
        end else begin
            state_reg       <= state_next;
            stage_reg       <= stage_next;
            pair_reg        <= pair_next;
            drain_reg       <= drain_next;
            bank_reg        <= bank_next;
            busy_reg        <= (state_next != ST_IDLE);
            input_en_reg    <= (state_next == ST_LOAD);
            issue_valid_reg <= (state_next == ST_ISSUE);
            output_en_reg   <= (state_next == ST_UNLOAD);
            done_reg        <= (state_reg == ST_UNLOAD) && output_done;
        end
    end

    buffer #(
        .buffer_length(WB_LAT),
        .vector_size  (1)
    ) u_wb_delay (
        .clk  (clk),
        .reset(reset),
        .d    (issue_valid_reg),
        .q    (wb_en)
    );

`ifdef FFT_SEQ_CYCLE_CNT_EN
    logic [31:0] cycle_count_reg;

    // Counts the acceptance cycle through the done cycle, then holds.
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_count_reg <= '0;
        end else if (accept) begin
            cycle_count_reg <= 32'd1;
        end else if ((state_reg != ST_IDLE) && (cycle_count_reg != '1)) begin
            cycle_count_reg <= cycle_count_reg + 32'd1;
        end
    end

    assign cycle_count = cycle_count_reg;
`endif

    assign busy        = busy_reg;
    assign input_en    = input_en_reg;
    assign stage       = stage_reg;
    assign pair_id     = pair_reg;
    assign issue_valid = issue_valid_reg;
    assign bank_select = bank_reg;
    assign output_en   = output_en_reg;
    assign done        = done_reg;

endmodule

// File: tb/tb_fft_sequencer.sv
// Scoreboard bench for fft_sequencer: a 32-point and a 4-point instance, with
// expected issue/write-back/unload/done events queued by the stimulus.
module tb_fft_sequencer;

    localparam int WB = 3;  // rd_latency 1 + mult_latency 2

    typedef struct {
        int cyc;
        int stage;
        int pair;
        int bank;
        int cnt;
    } ev_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       reset = 1'b1;
    logic [1:0] start_v = '0, idone_v = '0, odone_v = '0;

    logic       busy, input_en, issue_valid, wb_en, bank_select, output_en, done;
    logic [2:0] stage;
    logic [3:0] pair_id;
    logic       busy4, input_en4, issue_valid4, wb_en4, bank_select4, output_en4, done4;
    logic [0:0] stage4;
    logic [0:0] pair_id4;
`ifdef FFT_SEQ_CYCLE_CNT_EN
    logic [31:0] cycle_count, cycle_count4;
`endif

    fft_sequencer #(.N(32), .mult_latency(2), .rd_latency(1)) dut (
        .clk(clk), .reset(reset), .start(start_v[0]), .busy(busy),
        .input_en(input_en), .input_done(idone_v[0]), .stage(stage),
        .pair_id(pair_id), .issue_valid(issue_valid), .wb_en(wb_en),
        .bank_select(bank_select), .output_en(output_en),
        .output_done(odone_v[0]), .done(done)
`ifdef FFT_SEQ_CYCLE_CNT_EN
        , .cycle_count(cycle_count)
`endif
    );

    fft_sequencer #(.N(4), .mult_latency(2), .rd_latency(1)) dut4 (
        .clk(clk), .reset(reset), .start(start_v[1]), .busy(busy4),
        .input_en(input_en4), .input_done(idone_v[1]), .stage(stage4),
        .pair_id(pair_id4), .issue_valid(issue_valid4), .wb_en(wb_en4),
        .bank_select(bank_select4), .output_en(output_en4),
        .output_done(odone_v[1]), .done(done4)
`ifdef FFT_SEQ_CYCLE_CNT_EN
        , .cycle_count(cycle_count4)
`endif
    );

    int total = 0;
    int bad   = 0;
    int iss_seen0 = 0, wb_seen0 = 0, iss_seen1 = 0, wb_seen1 = 0;
    ev_t iss_q0[$], wb_q0[$], out_q0[$], done_q0[$];
    ev_t iss_q1[$], wb_q1[$], out_q1[$], done_q1[$];

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic g_busy(input int w);     return (w == 0) ? busy : busy4; endfunction
    function automatic logic g_input_en(input int w); return (w == 0) ? input_en : input_en4; endfunction
    function automatic logic g_bank(input int w);     return (w == 0) ? bank_select : bank_select4; endfunction
    function automatic logic g_oe(input int w);       return (w == 0) ? output_en : output_en4; endfunction

    // Monitor for the 32-point instance.
    ev_t m0;
    logic oe_prev0 = 1'b0;
    always @(negedge clk) begin
        if (issue_valid) begin
            iss_seen0++;
            if (iss_q0.size() == 0) chk("issue32_unexpected", cyc, -1);
            else begin
                m0 = iss_q0.pop_front();
                chk("issue32_cycle", cyc, m0.cyc);
                chk("issue32_stage", stage, m0.stage);
                chk("issue32_pair", pair_id, m0.pair);
                chk("issue32_bank", bank_select, m0.bank);
            end
        end
        if (wb_en) begin
            wb_seen0++;
            if (wb_q0.size() == 0) chk("wb32_unexpected", cyc, -1);
            else begin
                m0 = wb_q0.pop_front();
                chk("wb32_cycle", cyc, m0.cyc);
            end
        end
        if (output_en && !oe_prev0) begin
            if (out_q0.size() == 0) chk("unload32_unexpected", cyc, -1);
            else begin
                m0 = out_q0.pop_front();
                chk("unload32_cycle", cyc, m0.cyc);
                chk("unload32_bank", bank_select, m0.bank);
            end
        end
        oe_prev0 <= output_en;
        if (done) begin
            if (done_q0.size() == 0) chk("done32_unexpected", cyc, -1);
            else begin
                m0 = done_q0.pop_front();
                chk("done32_cycle", cyc, m0.cyc);
`ifdef FFT_SEQ_CYCLE_CNT_EN
                chk("done32_cycle_count", cycle_count, m0.cnt);
`endif
            end
        end
    end

    // Monitor for the 4-point instance.
    ev_t m1;
    logic oe_prev1 = 1'b0;
    always @(negedge clk) begin
        if (issue_valid4) begin
            iss_seen1++;
            if (iss_q1.size() == 0) chk("issue4_unexpected", cyc, -1);
            else begin
                m1 = iss_q1.pop_front();
                chk("issue4_cycle", cyc, m1.cyc);
                chk("issue4_stage", stage4, m1.stage);
                chk("issue4_pair", pair_id4, m1.pair);
                chk("issue4_bank", bank_select4, m1.bank);
            end
        end
        if (wb_en4) begin
            wb_seen1++;
            if (wb_q1.size() == 0) chk("wb4_unexpected", cyc, -1);
            else begin
                m1 = wb_q1.pop_front();
                chk("wb4_cycle", cyc, m1.cyc);
            end
        end
        if (output_en4 && !oe_prev1) begin
            if (out_q1.size() == 0) chk("unload4_unexpected", cyc, -1);
            else begin
                m1 = out_q1.pop_front();
                chk("unload4_cycle", cyc, m1.cyc);
                chk("unload4_bank", bank_select4, m1.bank);
            end
        end
        oe_prev1 <= output_en4;
        if (done4) begin
            if (done_q1.size() == 0) chk("done4_unexpected", cyc, -1);
            else begin
                m1 = done_q1.pop_front();
                chk("done4_cycle", cyc, m1.cyc);
`ifdef FFT_SEQ_CYCLE_CNT_EN
                chk("done4_cycle_count", cycle_count4, m1.cnt);
`endif
            end
        end
    end

    function automatic int log2i(input int n);
        int lg = 0;
        for (int v = n; v > 1; v = v / 2) lg++;
        return lg;
    endfunction

    // Expected issue/write-back/unload events when the first issue lands at t0.
    task automatic push_transform(input int w, input int n, input int t0);
        ev_t e;
        int  lg  = log2i(n);
        int  per = n / 2 + WB;
        e.cnt = 0;
        for (int s = 0; s < lg; s++) begin
            for (int p = 0; p < n / 2; p++) begin
                e.cyc = t0 + s * per + p; e.stage = s; e.pair = p; e.bank = s % 2;
                if (w == 0) iss_q0.push_back(e); else iss_q1.push_back(e);
                e.cyc = e.cyc + WB;
                if (w == 0) wb_q0.push_back(e); else wb_q1.push_back(e);
            end
        end
        e.cyc = t0 + lg * per; e.stage = 0; e.pair = 0; e.bank = lg % 2;
        if (w == 0) out_q0.push_back(e); else out_q1.push_back(e);
    endtask

    task automatic run(input int w, input int n, input int n_in, input int n_out, input bit spurious);
        ev_t e;
        int  lg = log2i(n);
        int  guard;
        int  iss0 = (w == 0) ? iss_seen0 : iss_seen1;
        int  wb0  = (w == 0) ? wb_seen0 : wb_seen1;
        int  t_done;
        start_v[w] = 1'b1; step(); start_v[w] = 1'b0;
        chk("load_input_en", g_input_en(w), 1);
        chk("load_bank", g_bank(w), 1);
        for (int i = 1; i < n_in; i++) begin
            if (spurious && i == 3) odone_v[w] = 1'b1;
            step();
            odone_v[w] = 1'b0;
        end
        push_transform(w, n, cyc + 1);
        idone_v[w] = 1'b1; step(); idone_v[w] = 1'b0;
        guard = 0;
        while (!g_oe(w) && guard < 400) begin
            if (spurious && guard == 5) begin
                start_v[w] = 1'b1;
                idone_v[w] = 1'b1;
            end
            step();
            start_v[w] = 1'b0;
            idone_v[w] = 1'b0;
            guard++;
        end
        chk("unload_reached", g_oe(w), 1);
        for (int i = 1; i < n_out; i++) step();
        t_done = cyc + 1;
        e.cyc = t_done; e.stage = 0; e.pair = 0; e.bank = 0;
        e.cnt = n_in + lg * (n / 2 + WB) + n_out + 1;
        if (w == 0) done_q0.push_back(e); else done_q1.push_back(e);
        odone_v[w] = 1'b1; step(); odone_v[w] = 1'b0;
        start_v[w] = 1'b1; step(); start_v[w] = 1'b0;
        chk("idle_after_done_busy", g_busy(w), 0);
        chk("idle_after_done_input_en", g_input_en(w), 0);
        for (int i = 0; i < WB + 2; i++) step();
        chk("issue_count", ((w == 0) ? iss_seen0 : iss_seen1) - iss0, lg * n / 2);
        chk("wb_count", ((w == 0) ? wb_seen0 : wb_seen1) - wb0, lg * n / 2);
        chk("queues_drained", (w == 0) ? (iss_q0.size() + wb_q0.size() + out_q0.size() + done_q0.size())
                                       : (iss_q1.size() + wb_q1.size() + out_q1.size() + done_q1.size()), 0);
`ifdef FFT_SEQ_CYCLE_CNT_EN
        chk("cycle_count_hold", (w == 0) ? cycle_count : cycle_count4, e.cnt);
`endif
        $display("transform N=%0d in_wait=%0d out_wait=%0d issues=%0d wb=%0d done_cycle=%0d", n, n_in, n_out,
                 ((w == 0) ? iss_seen0 : iss_seen1) - iss0, ((w == 0) ? wb_seen0 : wb_seen1) - wb0, t_done);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        int wb_before;
        repeat (3) step();
        reset = 1'b0;
        step();
        chk("reset_busy", busy, 0);
        chk("reset_input_en", input_en, 0);
        chk("reset_issue_valid", issue_valid, 0);
        chk("reset_stage_pair", {stage, pair_id}, 0);
        chk("reset_bank", bank_select, 0);
        chk("reset_output_en_done", {output_en, done, wb_en}, 0);
`ifdef FFT_SEQ_CYCLE_CNT_EN
        chk("reset_cycle_count", cycle_count, 0);
`endif
        $display("reset check done at cycle %0d", cyc);

        run(0, 32, 10, 10, 1'b1);

        // Abort mid-ISSUE at stage 2, pair 7.
        start_v[0] = 1'b1; step(); start_v[0] = 1'b0;
        push_transform(0, 32, cyc + 1);
        idone_v[0] = 1'b1; step(); idone_v[0] = 1'b0;
        guard = 0;
        while (!(stage == 3'd2 && pair_id == 4'd7) && guard < 200) begin
            step();
            guard++;
        end
        chk("abort_point_reached", {stage, pair_id}, {3'd2, 4'd7});
        reset = 1'b1; step();
        chk("abort_busy", busy, 0);
        chk("abort_issue_valid", issue_valid, 0);
        chk("abort_stage_pair", {stage, pair_id}, 0);
        chk("abort_bank", bank_select, 0);
        chk("abort_wb_en", wb_en, 0);
        chk("abort_other_outputs", {input_en, output_en, done}, 0);
        reset = 1'b0;
        iss_q0.delete(); wb_q0.delete(); out_q0.delete(); done_q0.delete();
        wb_before = wb_seen0;
        repeat (8) step();
        chk("abort_no_wb_after", wb_seen0 - wb_before, 0);
        chk("abort_stays_idle", busy, 0);
        $display("reset abort at stage 2 pair 7 done at cycle %0d", cyc);

        run(1, 4, 3, 2, 1'b0);
        run(0, 32, 4, 6, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fft_sequencer.md
# fft_sequencer

Top-level control FSM for the in-place radix-2 FFT core. Sequences one transform per `start`: hands memory to the input loader, issues every butterfly (stage, pair_id) to the AGU in order, gates BPU write-back, ping-pongs the RAM banks per stage, then hands memory to the output unloader. Sits beside the AGU, BPU, RAM interface and input/output modules in the FFT top; owns no datapath.

## Interface
- `N`, 32: transform length; power of two, ≥ 4.
- `mult_latency`, 2: BPU multiplier pipeline depth in cycles.
- `rd_latency`, 1: RAM/twiddle ROM read latency in cycles.
- Derived locals: `LOG2N = $clog2(N)`, `stage_width = $clog2(LOG2N)`, `pair_id_width = $clog2(N/2)`, `WB_LAT = rd_latency + mult_latency`.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  request a transform; accepted only in IDLE.
- `busy`  out  1  high in every state except IDLE.
- `input_en`  out  1  grants RAM write port to the input loader (LOAD state).
- `input_done`  in  1  one-cycle pulse from the loader; ends LOAD.
- `stage`  out  stage_width  current butterfly stage, 0..LOG2N-1.
- `pair_id`  out  pair_id_width  butterfly index within the stage, 0..N/2-1.
- `issue_valid`  out  1  `stage`/`pair_id` drive a real butterfly this cycle.
- `wb_en`  out  1  BPU result write enable; `issue_valid` delayed by WB_LAT.
- `bank_select`  out  1  RAM bank being read; writes go to the other bank.
- `output_en`  out  1  grants RAM read port to the output unloader (UNLOAD state).
- `output_done`  in  1  one-cycle pulse from the unloader; ends UNLOAD.
- `done`  out  1  one-cycle pulse on the UNLOAD→IDLE transition.

## Operation
- States: IDLE, LOAD, ISSUE, DRAIN, UNLOAD.
- IDLE: all outputs 0. `start`=1 → LOAD.
- LOAD: `input_en`=1, `bank_select`=1 (loader writes bank 0). `input_done`=1 → ISSUE with stage=0, pair_id=0.
- ISSUE: `issue_valid`=1; `pair_id` increments each cycle. When pair_id = N/2-1 → DRAIN, and pair_id wraps to 0.
- DRAIN: `issue_valid`=0 for exactly WB_LAT cycles (drain counter) so the last write-backs of the stage land before the next stage reads. At the end of the drain: if stage = LOG2N-1 → UNLOAD; otherwise stage+1, toggle `bank_select`, → ISSUE.
- During stage s, `bank_select` = s mod 2.
- UNLOAD: `output_en`=1, `bank_select` = LOG2N mod 2 (the bank holding the final result; for N=32, bank 1). `output_done`=1 → IDLE with `done`=1 for that cycle.
- `wb_en`: shift register of depth WB_LAT fed by `issue_valid`. It keeps running through DRAIN, and is guaranteed 0 by the time the FSM leaves DRAIN.
- Ignored events: `start` outside IDLE, including the same cycle as `done`; `input_done` outside LOAD; `output_done` outside UNLOAD.
- Counters never exceed range: pair_id wraps at N/2; stage never passes LOG2N-1.

## Timing
- Reset, synchronous: state=IDLE, stage=0, pair_id=0, drain counter=0, `wb_en` shift register cleared, `bank_select`=0, all other outputs 0. Reset mid-transform aborts immediately; no `done` pulse.
- `start` sampled at edge k → `input_en`=1 from cycle k+1.
- `input_done` at edge k → `issue_valid`=1 with stage 0, pair 0 at cycle k+1.
- Per stage: N/2 issue cycles plus WB_LAT drain cycles.
- Compute phase: LOG2N·(N/2+WB_LAT) cycles. Defaults: 5·(16+3) = 95 cycles.
- First `wb_en` arrives WB_LAT cycles after the first `issue_valid`.
- All outputs are registered; no combinational path from input to output.

## Configuration
- `FFT_SEQ_CYCLE_CNT_EN` defined:
  - adds output `cycle_count` (32 bits), 0 at reset;
  - counts cycles from `start` acceptance up to and including the `done` cycle;
  - holds that value until the next accepted `start` clears it;
  - saturates at 2^32-1.
- Undefined: the port and the counter do not exist; behaviour is otherwise identical.

## Structure
- Shared package `fft_pkg`: state enum (IDLE, LOAD, ISSUE, DRAIN, UNLOAD), width helpers (`stage_width`, `pair_id_width`), and the WB_LAT derivation. The AGU, BPU and top use the same helpers.
- One sub-module: the `wb_en` delay line is an instance of the team's existing `buffer` module with `buffer_length=WB_LAT` and `vector_size=1`. Everything else is inline FSM and counters.

## Test plan
- Reset mid-ISSUE (stage 2, pair 7) → next cycle: IDLE, all outputs 0, `bank_select`=0, no `wb_en` pulses afterwards.
- Full transform, defaults: `start`; `input_done` 10 cycles later → exactly 80 `issue_valid` cycles and 80 `wb_en` cycles; 95 cycles from first issue to `output_en`; `bank_select` 0,1,0,1,0 per stage, then 1 in UNLOAD.
- `start` pulsed during ISSUE and in the same cycle as `done` → both ignored; FSM stays IDLE after `done`.
- Spurious `input_done` in ISSUE and spurious `output_done` in LOAD → no state change.
- N=4, mult_latency=2 → 2 stages of 2 issues + 3 drain cycles each; UNLOAD `bank_select`=0.
- With `FFT_SEQ_CYCLE_CNT_EN`, input_done/output_done each arriving 10 cycles after their enable → `cycle_count` = 10+95+10+1 = 116 at `done`, holds at 116 afterwards.
